// File: rtl/snitch_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snitch_mem_pkg
// Brief    : Shared types and the round-robin pick helper for the memory arbiter.
// Revision : 1.0
// ============================================================================
package snitch_mem_pkg;

  localparam int unsigned MaxPortsC = 8;

  typedef logic [$clog2(MaxPortsC)-1:0] port_idx_t;

  // Lowest valid index at or above ptr; falls back to the lowest valid index (wrap).
  function automatic port_idx_t rr_pick(input logic [MaxPortsC-1:0] valid,
                                        input port_idx_t            ptr,
                                        input int                   num_ports);
    port_idx_t lo;
    port_idx_t hi;
    logic      hi_found;
    lo       = '0;
    hi       = '0;
    hi_found = 1'b0;
    for (int i = MaxPortsC - 1; i >= 0; i--) begin
      if (i < num_ports && valid[i]) begin
        lo = port_idx_t'(i);
        if (i >= int'(ptr)) begin
          hi       = port_idx_t'(i);
          hi_found = 1'b1;
        end
      end
    end
    return hi_found ? hi : lo;
  endfunction

endpackage
`default_nettype wire

// File: rtl/snitch_mem_id_fifo.sv
`default_nettype none
// ============================================================================
// Module   : snitch_mem_id_fifo
// Brief    : In-order FIFO of requester indices used to route memory responses.
// Revision : 1.0
// ============================================================================
module snitch_mem_id_fifo
  import snitch_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  port_idx_t        push_data_i,
  input  logic             pop_i,
  output port_idx_t        head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  port_idx_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (r_count == CNT_W'(DEPTH));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign head_o  = r_mem[r_rptr];
  assign count_o = r_count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= next_ptr(r_wptr);
      if (w_pop)  r_rptr <= next_ptr(r_rptr);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= push_data_i;
  end

endmodule
`default_nettype wire

// File: rtl/snitch_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : snitch_mem_arbiter
// Brief    : N-to-1 request arbiter onto one memory port with in-order response routing.
// Revision : 1.0
// ============================================================================
module snitch_mem_arbiter
  import snitch_mem_pkg::*;
#(
  parameter int unsigned NumPorts       = 2,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned RoundRobin     = 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumPorts-1:0]                  req_valid_i,
  output logic [NumPorts-1:0]                  req_ready_o,
  input  logic [NumPorts*AddrWidth-1:0]        req_addr_i,
  input  logic [NumPorts-1:0]                  req_write_i,
  input  logic [NumPorts*DataWidth-1:0]        req_wdata_i,
  input  logic [NumPorts*DataWidth/8-1:0]      req_wstrb_i,
  output logic [NumPorts-1:0]                  rsp_valid_o,
  output logic [DataWidth-1:0]                 rsp_rdata_o,
  output logic                                 mem_valid_o,
  input  logic                                 mem_ready_i,
  output logic [AddrWidth-1:0]                 mem_addr_o,
  output logic                                 mem_write_o,
  output logic [DataWidth-1:0]                 mem_wdata_o,
  output logic [DataWidth/8-1:0]               mem_wstrb_o,
  input  logic                                 mem_rvalid_i,
  input  logic [DataWidth-1:0]                 mem_rdata_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
  output logic                                 error_o
);

  localparam int unsigned CNT_W  = $clog2(MaxOutstanding + 1);
  localparam int unsigned STRB_W = DataWidth / 8;

  logic [MaxPortsC-1:0] w_valid_ext;
  port_idx_t            w_pick;
  port_idx_t            w_grant;
  port_idx_t            w_head;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_accept;
  logic                 w_pop;
  logic [CNT_W-1:0]     w_count;

  port_idx_t            r_ptr;
  logic                 r_lock;
  port_idx_t            r_lock_idx;
  logic                 r_error;

  always_comb begin
    w_valid_ext                 = '0;
    w_valid_ext[NumPorts-1:0]   = req_valid_i;
    w_pick = rr_pick(w_valid_ext, (RoundRobin != 0) ? r_ptr : port_idx_t'(0), int'(NumPorts));
  end

  // A stalled grant is frozen so a late higher-priority requester cannot steal it.
  assign w_grant     = r_lock ? r_lock_idx : w_pick;
  assign mem_valid_o = (|req_valid_i) && !w_full;
  assign w_accept    = mem_valid_o && mem_ready_i;
  assign w_pop       = mem_rvalid_i && !w_empty;

  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    mem_addr_o  = '0;
    mem_write_o = 1'b0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    for (int k = 0; k < int'(NumPorts); k++) begin
      if (w_grant == port_idx_t'(k)) begin
        mem_addr_o     = req_addr_i[k*AddrWidth +: AddrWidth];
        mem_write_o    = req_write_i[k];
        mem_wdata_o    = req_wdata_i[k*DataWidth +: DataWidth];
        mem_wstrb_o    = req_wstrb_i[k*STRB_W +: STRB_W];
        req_ready_o[k] = w_accept;
      end
      if (w_head == port_idx_t'(k)) rsp_valid_o[k] = w_pop;
    end
  end

  assign rsp_rdata_o   = mem_rdata_i;
  assign outstanding_o = w_count;
  assign error_o       = r_error;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr      <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_error    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_lock <= 1'b0;
        if (RoundRobin != 0) begin
          r_ptr <= (int'(w_grant) + 1 >= int'(NumPorts)) ? port_idx_t'(0)
                                                         : w_grant + port_idx_t'(1);
        end
      end else if (mem_valid_o) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_grant;
      end
      if (mem_rvalid_i && w_empty) r_error <= 1'b1;
    end
  end

  snitch_mem_id_fifo #(
    .DEPTH (MaxOutstanding),
    .CNT_W (CNT_W)
  ) u_id_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (w_accept),
    .push_data_i (w_grant),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .count_o     (w_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_snitch_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_snitch_mem_arbiter
// Brief    : Directed self-checking bench for the round-robin and fixed-priority arbiter.
// Revision : 1.0
// ============================================================================
module tb_snitch_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  always #5 clk = ~clk;

  // Round-robin instance
  logic [1:0]   req_valid, req_ready, req_write, rsp_valid;
  logic [63:0]  req_addr;
  logic [127:0] req_wdata;
  logic [15:0]  req_wstrb;
  logic [63:0]  rsp_rdata, mem_wdata, mem_rdata;
  logic         mem_valid, mem_ready, mem_write, mem_rvalid, error;
  logic [31:0]  mem_addr;
  logic [7:0]   mem_wstrb;
  logic [2:0]   outstanding;

  // Fixed-priority instance
  logic [1:0]   fp_req_valid, fp_req_ready, fp_rsp_valid;
  logic [63:0]  fp_rsp_rdata, fp_mem_wdata;
  logic         fp_mem_valid, fp_mem_ready, fp_mem_write, fp_mem_rvalid, fp_error;
  logic [31:0]  fp_mem_addr;
  logic [7:0]   fp_mem_wstrb;
  logic [2:0]   fp_outstanding;

  int n_checks = 0;
  int n_fail   = 0;

  snitch_mem_arbiter #(.NumPorts(2), .AddrWidth(32), .DataWidth(64),
                       .MaxOutstanding(4), .RoundRobin(1)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_write_i(req_write), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr),
    .mem_write_o(mem_write), .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .outstanding_o(outstanding), .error_o(error)
  );

  snitch_mem_arbiter #(.NumPorts(2), .AddrWidth(32), .DataWidth(64),
                       .MaxOutstanding(4), .RoundRobin(0)) dut_fp (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(fp_req_valid), .req_ready_o(fp_req_ready), .req_addr_i(req_addr),
    .req_write_i(req_write), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .rsp_valid_o(fp_rsp_valid), .rsp_rdata_o(fp_rsp_rdata),
    .mem_valid_o(fp_mem_valid), .mem_ready_i(fp_mem_ready), .mem_addr_o(fp_mem_addr),
    .mem_write_o(fp_mem_write), .mem_wdata_o(fp_mem_wdata), .mem_wstrb_o(fp_mem_wstrb),
    .mem_rvalid_i(fp_mem_rvalid), .mem_rdata_i(mem_rdata),
    .outstanding_o(fp_outstanding), .error_o(fp_error)
  );

  localparam logic [31:0] ADDR0 = 32'h0000_2000;
  localparam logic [31:0] ADDR1 = 32'h0001_0000;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 2'b00; fp_req_valid = 2'b00;
    mem_ready = 1'b0; fp_mem_ready = 1'b0;
    mem_rvalid = 1'b0; fp_mem_rvalid = 1'b0;
    mem_rdata = '0;
    req_write = 2'b00;
  endtask

  task automatic test_reset();
    idle();
    req_addr  = {ADDR1, ADDR0};
    req_wdata = '0;
    req_wstrb = '0;
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    #2;
    n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", error); end
    n_checks++; if ({mem_valid, req_ready, rsp_valid} !== 5'b0) begin n_fail++; $display("FAIL reset_outputs: got %b expected 00000", {mem_valid, req_ready, rsp_valid}); end
  endtask

  task automatic test_single_read();
    req_valid = 2'b10; mem_ready = 1'b1;
    #2;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL single_ready: got %b expected 10", req_ready); end
    n_checks++; if (mem_addr !== ADDR1) begin n_fail++; $display("FAIL single_addr: got %h expected %h", mem_addr, ADDR1); end
    cyc();
    idle();
    #2;
    n_checks++; if (outstanding !== 3'd1) begin n_fail++; $display("FAIL single_out1: got %0d expected 1", outstanding); end
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 64'h13;
    #2;
    n_checks++; if (rsp_valid !== 2'b10) begin n_fail++; $display("FAIL single_rsp_valid: got %b expected 10", rsp_valid); end
    n_checks++; if (rsp_rdata !== 64'h13) begin n_fail++; $display("FAIL single_rsp_data: got %h expected 13", rsp_rdata); end
    cyc();
    idle();
    #2;
    n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL single_out0: got %0d expected 0", outstanding); end
  endtask

  task automatic test_rr_fairness();
    logic [1:0] exp_rr [4];
    exp_rr[0] = 2'b01; exp_rr[1] = 2'b10; exp_rr[2] = 2'b01; exp_rr[3] = 2'b10;
    req_valid = 2'b11; mem_ready = 1'b1;
    fp_req_valid = 2'b11; fp_mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      n_checks++; if (req_ready !== exp_rr[i]) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, req_ready, exp_rr[i]); end
      n_checks++; if (fp_req_ready !== 2'b01) begin n_fail++; $display("FAIL fp_grant[%0d]: got %b expected 01", i, fp_req_ready); end
      cyc();
    end
    idle();
    mem_rvalid = 1'b1; fp_mem_rvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      n_checks++; if (rsp_valid !== exp_rr[i]) begin n_fail++; $display("FAIL rr_route[%0d]: got %b expected %b", i, rsp_valid, exp_rr[i]); end
      n_checks++; if (fp_rsp_valid !== 2'b01) begin n_fail++; $display("FAIL fp_route[%0d]: got %b expected 01", i, fp_rsp_valid); end
      cyc();
    end
    idle();
    #2;
    n_checks++; if ({outstanding, fp_outstanding} !== 6'd0) begin n_fail++; $display("FAIL rr_drained: got %0d/%0d expected 0/0", outstanding, fp_outstanding); end
  endtask

  task automatic test_lock();
    req_valid = 2'b10; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_checks++; if (mem_addr !== ADDR1 || req_ready !== 2'b00) begin n_fail++; $display("FAIL lock_stall[%0d]: got addr %h ready %b expected %h 00", i, mem_addr, req_ready, ADDR1); end
      cyc();
      req_valid = 2'b11;
    end
    mem_ready = 1'b1;
    #2;
    n_checks++; if (req_ready !== 2'b10 || mem_addr !== ADDR1) begin n_fail++; $display("FAIL lock_accept: got ready %b addr %h expected 10 %h", req_ready, mem_addr, ADDR1); end
    cyc();
    req_valid = 2'b01;
    #2;
    n_checks++; if (req_ready !== 2'b01 || mem_addr !== ADDR0) begin n_fail++; $display("FAIL lock_follow: got ready %b addr %h expected 01 %h", req_ready, mem_addr, ADDR0); end
    cyc();
    idle();
    mem_rvalid = 1'b1;
    #2;
    n_checks++; if (rsp_valid !== 2'b10) begin n_fail++; $display("FAIL lock_rsp0: got %b expected 10", rsp_valid); end
    cyc();
    #2;
    n_checks++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL lock_rsp1: got %b expected 01", rsp_valid); end
    cyc();
    idle();
  endtask

  task automatic test_full();
    req_valid = 2'b01; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      n_checks++; if (req_ready !== 2'b01 || outstanding !== 3'(i)) begin n_fail++; $display("FAIL full_fill[%0d]: got ready %b count %0d expected 01 %0d", i, req_ready, outstanding, i); end
      cyc();
    end
    mem_rvalid = 1'b1; mem_rdata = 64'h77;
    #2;
    n_checks++; if (mem_valid !== 1'b0 || req_ready !== 2'b00) begin n_fail++; $display("FAIL full_block: got valid %b ready %b expected 0 00", mem_valid, req_ready); end
    n_checks++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL full_pop: got %b expected 01", rsp_valid); end
    cyc();
    #2;
    n_checks++; if (outstanding !== 3'd3 || req_ready !== 2'b01) begin n_fail++; $display("FAIL full_resume: got count %0d ready %b expected 3 01", outstanding, req_ready); end
    cyc();
    mem_rvalid = 1'b0; req_valid = 2'b00;
    #2;
    n_checks++; if (outstanding !== 3'd3) begin n_fail++; $display("FAIL full_pushpop: got %0d expected 3", outstanding); end
    mem_rvalid = 1'b1;
    cyc(); cyc(); cyc();
    idle();
    #2;
    n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL full_drain: got %0d expected 0", outstanding); end
  endtask

  task automatic test_routing();
    logic [1:0]  ports [3];
    logic [63:0] data  [3];
    ports[0] = 2'b01; ports[1] = 2'b10; ports[2] = 2'b01;
    data[0] = 64'hA; data[1] = 64'hB; data[2] = 64'hC;
    req_wdata = {64'hDEAD_BEEF_0000_0001, 64'h0};
    req_wstrb = {8'hF0, 8'h00};
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid = ports[i];
      req_write = (i == 1) ? 2'b10 : 2'b00;
      #2;
      n_checks++; if (req_ready !== ports[i]) begin n_fail++; $display("FAIL route_req[%0d]: got %b expected %b", i, req_ready, ports[i]); end
      if (i == 1) begin
        n_checks++; if (mem_write !== 1'b1 || mem_wdata !== 64'hDEAD_BEEF_0000_0001 || mem_wstrb !== 8'hF0) begin n_fail++; $display("FAIL route_wpayload: got %b %h %h expected 1 deadbeef00000001 f0", mem_write, mem_wdata, mem_wstrb); end
      end
      cyc();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = 1'b1; mem_rdata = data[i];
      #2;
      n_checks++; if (rsp_valid !== ports[i] || rsp_rdata !== data[i]) begin n_fail++; $display("FAIL route_rsp[%0d]: got %b %h expected %b %h", i, rsp_valid, rsp_rdata, ports[i], data[i]); end
      cyc();
    end
    idle();
  endtask

  task automatic test_error_reset();
    mem_rvalid = 1'b1; mem_rdata = 64'h55;
    #2;
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL err_no_rsp: got %b expected 00", rsp_valid); end
    cyc();
    idle();
    cyc();
    #2;
    n_checks++; if (error !== 1'b1 || outstanding !== 3'd0) begin n_fail++; $display("FAIL err_sticky: got err %b count %0d expected 1 0", error, outstanding); end
    req_valid = 2'b01; mem_ready = 1'b1;
    cyc();
    req_valid = 2'b10;
    cyc();
    idle();
    #2;
    n_checks++; if (outstanding !== 3'd2) begin n_fail++; $display("FAIL err_pre_reset: got %0d expected 2", outstanding); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #2;
    n_checks++; if (outstanding !== 3'd0 || error !== 1'b0) begin n_fail++; $display("FAIL err_reset: got count %0d err %b expected 0 0", outstanding, error); end
    mem_rvalid = 1'b1;
    #2;
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL err_stale_rsp: got %b expected 00", rsp_valid); end
    cyc();
    idle();
    #2;
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL err_stale: got %b expected 1", error); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_rr_fairness();
    test_lock();
    test_full();
    test_routing();
    test_error_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
